// File: rtl/core_pkg.sv
// Shared encodings for the core control unit and the core datapath.
// Holds the bus source codes, ALU operation codes and the bit positions
// of the per-register load and increment enables, so both sides of the
// control/datapath boundary agree on a single definition.
package core_pkg;

  localparam int unsigned NUM_REGS = 10;

  // Bus source select codes. Codes 12-15 are unused and drive 0.
  typedef enum logic [3:0] {
    BUS_DMEM = 4'd0,
    BUS_IMEM = 4'd1,
    BUS_PC   = 4'd2,
    BUS_IR   = 4'd3,
    BUS_RL   = 4'd4,
    BUS_RC   = 4'd5,
    BUS_RP   = 4'd6,
    BUS_RQ   = 4'd7,
    BUS_R1   = 4'd8,
    BUS_AC   = 4'd9,
    BUS_R    = 4'd10,
    BUS_AR   = 4'd11
  } bus_sel_e;

  // ALU operation codes. Codes 6 and 7 hold the accumulator value.
  typedef enum logic [2:0] {
    ALU_CLR  = 3'd0,
    ALU_PASS = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_MUL  = 3'd4,
    ALU_INC  = 3'd5
  } alu_op_e;

  // Bit positions inside wrEnReg.
  localparam int WR_AC = 0;
  localparam int WR_R1 = 1;
  localparam int WR_RQ = 2;
  localparam int WR_RP = 3;
  localparam int WR_RC = 4;
  localparam int WR_RL = 5;
  localparam int WR_IR = 6;
  localparam int WR_PC = 7;
  localparam int WR_R  = 8;
  localparam int WR_AR = 9;

  // Bit positions inside incReg.
  localparam int INC_RQ = 0;
  localparam int INC_RP = 1;
  localparam int INC_RC = 2;
  localparam int INC_PC = 3;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU of the core datapath.
// Ports:
//   aluOp  - operation code (core_pkg alu codes)
//   a      - operand A (accumulator)
//   b      - operand B (bus)
//   result - operation result, truncated to REG_WIDTH
//   zero   - high when result is all zeros
module core_alu
  import core_pkg::*;
#(
  parameter int REG_WIDTH = 12
) (
  input  logic [2:0]           aluOp,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic [REG_WIDTH-1:0] result,
  output logic                 zero
);

  // All arithmetic is evaluated in REG_WIDTH context, so carries and the
  // upper half of the product are discarded (modulo 2^REG_WIDTH).
  always_comb begin
    result = a;
    case (aluOp)
      ALU_CLR:  result = '0;
      ALU_PASS: result = b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_MUL:  result = a * b;
      ALU_INC:  result = a + REG_WIDTH'(1);
      default:  result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/core_datapath.sv
// Per-core register-transfer datapath driven by the core control unit.
// Owns the shared bus mux, ten architectural registers, the ALU and the
// Z flag. No sequencing lives here: every register updates one clock
// after its control signals are presented.
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   wrEnReg     - load enables {AR,R,PC,IR,RL,RC,RP,RQ,R1,AC}
//   incReg      - increment enables {PC,RC,RP,RQ}
//   busSel      - bus source select
//   aluOp       - ALU operation
//   ZWrEn       - Z flag update enable
//   insMemIn    - instruction-memory read data
//   dataMemIn   - data-memory read data
//   ins         - IR low bits to the control unit
//   Zout        - registered zero flag
//   insMemAddr  - PC
//   dataMemAddr - AR
//   dataMemOut  - AC (store data)
//   busOut      - current bus value for trace
module core_datapath
  import core_pkg::*;
#(
  parameter int REG_WIDTH = 12,
  parameter int INS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           wrEnReg,
  input  logic [3:0]           incReg,
  input  logic [3:0]           busSel,
  input  logic [2:0]           aluOp,
  input  logic                 ZWrEn,
  input  logic [REG_WIDTH-1:0] insMemIn,
  input  logic [REG_WIDTH-1:0] dataMemIn,
  output logic [INS_WIDTH-1:0] ins,
  output logic                 Zout,
  output logic [REG_WIDTH-1:0] insMemAddr,
  output logic [REG_WIDTH-1:0] dataMemAddr,
  output logic [REG_WIDTH-1:0] dataMemOut,
  output logic [REG_WIDTH-1:0] busOut
);

  logic [REG_WIDTH-1:0] ar, r, pc, ir, rl, rc, rp, rq, r1, ac;
  logic                 z;
  logic [REG_WIDTH-1:0] bus;
  logic [REG_WIDTH-1:0] alu_result;
  logic                 alu_zero;

  always_comb begin
    bus = '0;
    case (busSel)
      BUS_DMEM: bus = dataMemIn;
      BUS_IMEM: bus = insMemIn;
      BUS_PC:   bus = pc;
      BUS_IR:   bus = ir;
      BUS_RL:   bus = rl;
      BUS_RC:   bus = rc;
      BUS_RP:   bus = rp;
      BUS_RQ:   bus = rq;
      BUS_R1:   bus = r1;
      BUS_AC:   bus = ac;
      BUS_R:    bus = r;
      BUS_AR:   bus = ar;
      default:  bus = '0;
    endcase
  end

  core_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .aluOp  (aluOp),
    .a      (ac),
    .b      (bus),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // A load on a register takes priority over its increment, so a
  // register that reads itself while incrementing keeps its old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar <= '0; r  <= '0; pc <= '0; ir <= '0; rl <= '0;
      rc <= '0; rp <= '0; rq <= '0; r1 <= '0; ac <= '0;
      z  <= 1'b0;
    end else begin
      if (wrEnReg[WR_AR]) ar <= bus;
      if (wrEnReg[WR_R])  r  <= bus;
      if (wrEnReg[WR_IR]) ir <= bus;
      if (wrEnReg[WR_RL]) rl <= bus;
      if (wrEnReg[WR_R1]) r1 <= bus;
      if (wrEnReg[WR_AC]) ac <= alu_result;

      if (wrEnReg[WR_PC])      pc <= bus;
      else if (incReg[INC_PC]) pc <= pc + REG_WIDTH'(1);

      if (wrEnReg[WR_RC])      rc <= bus;
      else if (incReg[INC_RC]) rc <= rc + REG_WIDTH'(1);

      if (wrEnReg[WR_RP])      rp <= bus;
      else if (incReg[INC_RP]) rp <= rp + REG_WIDTH'(1);

      if (wrEnReg[WR_RQ])      rq <= bus;
      else if (incReg[INC_RQ]) rq <= rq + REG_WIDTH'(1);

      if (ZWrEn) z <= alu_zero;
    end
  end

  assign ins         = ir[INS_WIDTH-1:0];
  assign Zout        = z;
  assign insMemAddr  = pc;
  assign dataMemAddr = ar;
  assign dataMemOut  = ac;
  assign busOut      = bus;

endmodule

// File: tb/tb_core_datapath.sv
// Directed bench for core_datapath. Expected values are queued before
// each clocked step and compared after the edge; registers are observed
// through the bus by steering busSel while all enables are idle.
module tb_core_datapath;

  localparam int W  = 12;
  localparam int IW = 8;

  // Load-enable masks
  localparam logic [9:0] M_AR = 10'h200, M_R  = 10'h100, M_PC = 10'h080,
                         M_IR = 10'h040, M_RL = 10'h020, M_RC = 10'h010,
                         M_RP = 10'h008, M_RQ = 10'h004, M_R1 = 10'h002,
                         M_AC = 10'h001;
  // Increment-enable masks
  localparam logic [3:0] I_PC = 4'h8, I_RC = 4'h4, I_RP = 4'h2, I_RQ = 4'h1;
  // Bus sources
  localparam int S_DMEM = 0, S_IMEM = 1, S_PC = 2, S_IR = 3, S_RL = 4,
                 S_RC = 5, S_RP = 6, S_RQ = 7, S_R1 = 8, S_AC = 9,
                 S_R = 10, S_AR = 11;
  // Non-bus observation points
  localparam int O_Z = 16, O_INS = 17, O_IADDR = 18, O_DADDR = 19, O_DOUT = 20;
  // ALU operations
  localparam logic [2:0] OP_CLR = 3'd0, OP_PASS = 3'd1, OP_ADD = 3'd2,
                         OP_SUB = 3'd3, OP_MUL = 3'd4, OP_INC = 3'd5,
                         OP_H6 = 3'd6, OP_H7 = 3'd7;

  logic          clk;
  logic          rst;
  logic [9:0]    wrEnReg;
  logic [3:0]    incReg;
  logic [3:0]    busSel;
  logic [2:0]    aluOp;
  logic          ZWrEn;
  logic [W-1:0]  insMemIn;
  logic [W-1:0]  dataMemIn;
  logic [IW-1:0] ins;
  logic          Zout;
  logic [W-1:0]  insMemAddr;
  logic [W-1:0]  dataMemAddr;
  logic [W-1:0]  dataMemOut;
  logic [W-1:0]  busOut;

  core_datapath #(.REG_WIDTH(W), .INS_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wrEnReg     (wrEnReg),
    .incReg      (incReg),
    .busSel      (busSel),
    .aluOp       (aluOp),
    .ZWrEn       (ZWrEn),
    .insMemIn    (insMemIn),
    .dataMemIn   (dataMemIn),
    .ins         (ins),
    .Zout        (Zout),
    .insMemAddr  (insMemAddr),
    .dataMemAddr (dataMemAddr),
    .dataMemOut  (dataMemOut),
    .busOut      (busOut)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           obs_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic expect_out(input int obs, input logic [W-1:0] val, input string tag);
    obs_q.push_back(obs);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    int           obs;
    logic [W-1:0] e;
    logic [W-1:0] got;
    string        tag;
    while (exp_q.size() > 0) begin
      obs = obs_q.pop_front();
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      if (obs < 16) begin
        busSel = 4'(obs);
        #1;
        got = busOut;
      end else begin
        #1;
        case (obs)
          O_Z:     got = {{(W-1){1'b0}}, Zout};
          O_INS:   got = {{(W-IW){1'b0}}, ins};
          O_IADDR: got = insMemAddr;
          O_DADDR: got = dataMemAddr;
          default: got = dataMemOut;
        endcase
      end
      checks++;
      assert (got === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, got, e);
      end
    end
  endtask

  // Drivers
  task automatic step(input logic r, input logic [9:0] we, input logic [3:0] inc,
                      input int sel, input logic [2:0] op, input logic zw,
                      input logic [W-1:0] im, input logic [W-1:0] dm);
    @(negedge clk);
    rst = r; wrEnReg = we; incReg = inc; busSel = 4'(sel);
    aluOp = op; ZWrEn = zw; insMemIn = im; dataMemIn = dm;
    @(posedge clk);
    #1;
    rst = 1'b0; wrEnReg = '0; incReg = '0; ZWrEn = 1'b0;
  endtask

  task automatic load_dm(input logic [9:0] we, input logic [W-1:0] v);
    step(1'b0, we, 4'h0, S_DMEM, OP_PASS, 1'b0, '0, v);
  endtask

  task automatic alu_dm(input logic [2:0] op, input logic [W-1:0] v, input logic zw);
    step(1'b0, M_AC, 4'h0, S_DMEM, op, zw, '0, v);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int s = 2; s <= 15; s++) expect_out(s, '0, $sformatf("%s_bus%0d", tag, s));
    expect_out(O_Z, '0, {tag, "_z"});
    expect_out(O_INS, '0, {tag, "_ins"});
    expect_out(O_IADDR, '0, {tag, "_iaddr"});
    expect_out(O_DADDR, '0, {tag, "_daddr"});
    expect_out(O_DOUT, '0, {tag, "_dout"});
  endtask

  logic [W-1:0] v;

  initial begin
    rst = 1'b1; wrEnReg = 10'h3FF; incReg = 4'hF; busSel = 4'(S_IMEM);
    aluOp = OP_PASS; ZWrEn = 1'b1; insMemIn = 12'hABC; dataMemIn = 12'h000;

    // Reset overrides every load and increment
    expect_all_zero("reset");
    step(1'b1, 10'h3FF, 4'hF, S_IMEM, OP_PASS, 1'b1, 12'hABC, '0);
    drain();

    // Fetch: IR load with PC increment
    expect_out(O_INS, 12'h00B, "fetch_ins");
    expect_out(O_IADDR, 12'h001, "fetch_pc");
    expect_out(S_IR, 12'h00B, "fetch_ir");
    step(1'b0, M_IR, I_PC, S_IMEM, OP_H6, 1'b0, 12'h00B, '0);
    drain();

    // PASS / SUB / INC with Z
    expect_out(O_DOUT, 12'h005, "pass_ac");
    alu_dm(OP_PASS, 12'h005, 1'b0);
    drain();
    expect_out(S_AC, 12'h000, "sub_ac");
    expect_out(O_Z, 12'h001, "sub_z");
    alu_dm(OP_SUB, 12'h005, 1'b1);
    drain();
    expect_out(S_AC, 12'h001, "inc_ac");
    expect_out(O_Z, 12'h000, "inc_z");
    alu_dm(OP_INC, 12'h005, 1'b1);
    drain();

    // Z holds when ZWrEn is low, in both directions
    expect_out(S_AC, 12'h000, "clr_ac");
    expect_out(O_Z, 12'h000, "zhold_zero_result");
    alu_dm(OP_CLR, 12'h005, 1'b0);
    drain();
    expect_out(O_Z, 12'h001, "clr_z");
    alu_dm(OP_CLR, 12'h005, 1'b1);
    drain();
    expect_out(S_AC, 12'h005, "zhold_ac");
    expect_out(O_Z, 12'h001, "zhold_nonzero_result");
    alu_dm(OP_PASS, 12'h005, 1'b0);
    drain();

    // RC wrap
    expect_out(S_RC, 12'hFFF, "rc_load");
    load_dm(M_RC, 12'hFFF);
    drain();
    expect_out(S_RC, 12'h000, "rc_wrap");
    step(1'b0, '0, I_RC, S_DMEM, OP_H6, 1'b0, '0, '0);
    drain();

    // Truncating multiply, add carry into msb, subtract borrow
    alu_dm(OP_PASS, 12'h800, 1'b0);
    expect_out(S_AC, 12'h000, "mul_trunc");
    expect_out(O_Z, 12'h001, "mul_z");
    alu_dm(OP_MUL, 12'h002, 1'b1);
    drain();
    alu_dm(OP_PASS, 12'h7FF, 1'b0);
    expect_out(S_AC, 12'h800, "add_msb");
    expect_out(O_Z, 12'h000, "add_z");
    alu_dm(OP_ADD, 12'h001, 1'b1);
    drain();
    expect_out(O_DOUT, 12'hFFF, "sub_borrow");
    alu_dm(OP_SUB, 12'h801, 1'b0);
    drain();

    // Load beats increment; then plain increments of RP and RQ
    expect_out(S_RP, 12'h123, "conflict_rp");
    step(1'b0, M_RP, I_RP, S_DMEM, OP_PASS, 1'b0, '0, 12'h123);
    drain();
    expect_out(S_RP, 12'h124, "inc_rp");
    expect_out(S_RQ, 12'h001, "inc_rq");
    step(1'b0, '0, I_RP | I_RQ, S_DMEM, OP_H6, 1'b0, '0, '0);
    drain();

    // Broadcast of one bus value into several registers
    v = W'($urandom_range(1, 4095));
    expect_out(S_RP, v, "bcast_rp");
    expect_out(S_RQ, v, "bcast_rq");
    expect_out(S_AR, v, "bcast_ar");
    expect_out(S_R, v, "bcast_r");
    expect_out(S_R1, v, "bcast_r1");
    expect_out(S_RL, v, "bcast_rl");
    expect_out(O_DADDR, v, "bcast_daddr");
    expect_out(S_AC, 12'hFFF, "bcast_ac_untouched");
    for (int s = 12; s <= 15; s++) expect_out(s, '0, $sformatf("unused_bus%0d", s));
    load_dm(M_RP | M_RQ | M_AR | M_R | M_R1 | M_RL, v);
    drain();

    // PC reading itself while incrementing keeps its value
    expect_out(O_IADDR, 12'h001, "self_pc");
    step(1'b0, M_PC, I_PC, S_PC, OP_H6, 1'b0, '0, '0);
    drain();
    // AC + PC over the bus: 0xFFF + 1 wraps
    expect_out(O_DOUT, 12'h000, "add_pc_wrap");
    step(1'b0, M_AC, 4'h0, S_PC, OP_ADD, 1'b0, '0, '0);
    drain();

    // Hold operations ignore the bus
    v = W'($urandom_range(1, 4095));
    alu_dm(OP_PASS, v, 1'b1);
    expect_out(S_AC, v, "hold6_ac");
    expect_out(O_Z, 12'h000, "hold6_z");
    alu_dm(OP_H6, 12'h000, 1'b1);
    drain();
    expect_out(S_AC, v, "hold7_ac");
    alu_dm(OP_H7, 12'h000, 1'b1);
    drain();

    // Only the low IR bits reach ins
    expect_out(O_INS, 12'h0A5, "ins_trunc");
    expect_out(S_IR, 12'hFA5, "ir_full");
    step(1'b0, M_IR, 4'h0, S_IMEM, OP_H6, 1'b0, 12'hFA5, '0);
    drain();

    // Reset mid-instruction wins over everything
    expect_all_zero("midreset");
    step(1'b1, 10'h3FF, 4'hF, S_DMEM, OP_INC, 1'b1, 12'hFFF, 12'h777);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
